// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator: expands instr[31:7] to an XLEN-bit immediate and
// queues {imm, tag, err} in a 2-entry in-order buffer with valid/ready on both sides.
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_inst,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  // Type codes; RTYPE shares 3'b111 with "no immediate", so both report err.
  localparam logic [2:0] ITYPE  = 3'd0;
  localparam logic [2:0] STYPE  = 3'd1;
  localparam logic [2:0] BTYPE  = 3'd2;
  localparam logic [2:0] UTYPE  = 3'd3;
  localparam logic [2:0] JTYPE  = 3'd4;
  localparam logic [2:0] ZTYPE  = 3'd5;
  localparam logic [2:0] SHTYPE = 3'd6;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t             state;
  logic [XLEN-1:0]    imm0, imm1;
  logic [TAG_W-1:0]   tag0, tag1;
  logic               err0, err1;
  logic [31:7]        i;
  logic [XLEN-1:0]    new_imm;
  logic               new_err;
  logic               push, pop;

  assign i = in_inst;

  // Expansion happens before the buffer, so stored entries are already final.
  always_comb begin
    new_imm = '0;
    new_err = 1'b0;
    case (in_type)
      ITYPE:  new_imm = {{(XLEN-12){i[31]}}, i[31:20]};
      STYPE:  new_imm = {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
      BTYPE:  new_imm = {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      UTYPE:  new_imm = {{(XLEN-31){i[31]}}, i[30:12], 12'b0};
      JTYPE:  new_imm = {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      ZTYPE:  new_imm = {{(XLEN-5){1'b0}}, i[19:15]};
      SHTYPE: new_imm = (XLEN == 64) ? {{(XLEN-6){1'b0}}, i[25:20]}
                                     : {{(XLEN-5){1'b0}}, i[24:20]};
      default: new_err = 1'b1;
    endcase
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_imm = imm0;
  assign out_tag = tag0;
  assign out_err = err0;

  // Slot 0 is always the head; slot 1 only holds the second entry while FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      imm0  <= '0;
      tag0  <= '0;
      err0  <= 1'b0;
      imm1  <= '0;
      tag1  <= '0;
      err1  <= 1'b0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            imm0  <= new_imm;
            tag0  <= in_tag;
            err0  <= new_err;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            imm0 <= new_imm;
            tag0 <= in_tag;
            err0 <= new_err;
          end else if (push) begin
            imm1  <= new_imm;
            tag1  <= in_tag;
            err1  <= new_err;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            imm0  <= imm1;
            tag0  <= tag1;
            err0  <= err1;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances share stimulus; a scoreboard
// queue holds accepted entries and a negedge monitor compares every popped output.
module tb_imm_extend_pipe;

  localparam logic [2:0] ITYPE  = 3'd0;
  localparam logic [2:0] STYPE  = 3'd1;
  localparam logic [2:0] BTYPE  = 3'd2;
  localparam logic [2:0] UTYPE  = 3'd3;
  localparam logic [2:0] JTYPE  = 3'd4;
  localparam logic [2:0] ZTYPE  = 3'd5;
  localparam logic [2:0] SHTYPE = 3'd6;
  localparam logic [2:0] RTYPE  = 3'd7;

  typedef struct {
    logic [24:0] inst;
    logic [2:0]  ty;
    logic [31:0] tag;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst, flush, inValid, outReady;
  logic [24:0] inInst;
  logic [2:0]  inType;
  logic [31:0] inTag;
  logic        inReady32, outValid32, outErr32;
  logic [31:0] outImm32, outTag32;
  logic        inReady64, outValid64, outErr64;
  logic [63:0] outImm64;
  logic [31:0] outTag64;

  entry_t      sbQueue[$];
  entry_t      monEntry;
  logic [64:0] monExp32, monExp64;
  int          passCount = 0;
  int          checkCount = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady32),
    .in_inst(inInst), .in_type(inType), .in_tag(inTag), .out_valid(outValid32),
    .out_ready(outReady), .out_imm(outImm32), .out_tag(outTag32), .out_err(outErr32));

  imm_extend_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady64),
    .in_inst(inInst), .in_type(inType), .in_tag(inTag), .out_valid(outValid64),
    .out_ready(outReady), .out_imm(outImm64), .out_tag(outTag64), .out_err(outErr64));

  // Reference expansion built from masks and shifts; returns {err, imm64}.
  function automatic logic [64:0] modelImm(input logic [24:0] inst, input logic [2:0] ty,
                                           input bit is64);
    logic [31:0] ins;
    logic [63:0] ones, r;
    logic        err;
    ins  = {inst, 7'b0};
    ones = ins[31] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
    r    = 64'h0;
    err  = 1'b0;
    case (ty)
      ITYPE:  r = (ones << 12) | 64'(ins[31:20]);
      STYPE:  r = (ones << 12) | (64'(ins[31:25]) << 5) | 64'(ins[11:7]);
      BTYPE:  r = (ones << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      UTYPE:  r = (ones << 32) | (64'(ins[31:12]) << 12);
      JTYPE:  r = (ones << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      ZTYPE:  r = 64'(ins[19:15]);
      SHTYPE: r = is64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
      default: err = 1'b1;
    endcase
    return {err, r};
  endfunction

  // Scoreboard monitor: flush empties the expectation queue, every pop is compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (flush) begin
        sbQueue.delete();
      end else if (outValid32 && outReady) begin
        if (sbQueue.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL pop_unexpected: got tag %0d, required no output", outTag32);
        end else begin
          monEntry = sbQueue.pop_front();
          monExp32 = modelImm(monEntry.inst, monEntry.ty, 1'b0);
          monExp64 = modelImm(monEntry.inst, monEntry.ty, 1'b1);
          checkCount++;
          if (outTag32 !== monEntry.tag || outImm32 !== monExp32[31:0] || outErr32 !== monExp32[64])
            $display("[TB] FAIL pop32: got tag %0d imm %h err %b, required tag %0d imm %h err %b",
                     outTag32, outImm32, outErr32, monEntry.tag, monExp32[31:0], monExp32[64]);
          else passCount++;
          checkCount++;
          if (outValid64 !== 1'b1 || outTag64 !== monEntry.tag || outImm64 !== monExp64[63:0] ||
              outErr64 !== monExp64[64])
            $display("[TB] FAIL pop64: got v %b tag %0d imm %h err %b, required v 1 tag %0d imm %h err %b",
                     outValid64, outTag64, outImm64, outErr64, monEntry.tag, monExp64[63:0], monExp64[64]);
          else passCount++;
        end
      end
    end
  end

  // Holds in_valid until accepted; records the entry at the accepting edge.
  task automatic sendEntry(input logic [24:0] inst, input logic [2:0] ty, input logic [31:0] tag);
    int  waitCycles = 0;
    bit  done = 1'b0;
    inValid = 1'b1;
    inInst  = inst;
    inType  = ty;
    inTag   = tag;
    while (!done) begin
      @(negedge clk);
      if (inReady32) begin
        sbQueue.push_back(entry_t'{inst, ty, tag});
        done = 1'b1;
      end else if (waitCycles++ > 50) begin
        checkCount++;
        $display("[TB] FAIL accept_timeout: tag %0d never accepted, required accept within 50 cycles", tag);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (sbQueue.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkCount++;
    if (sbQueue.size() != 0)
      $display("[TB] FAIL %s_drain: got %0d entries outstanding, required 0", name, sbQueue.size());
    else passCount++;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    inInst = '0; inType = '0; inTag = '0;
    #12;
    checkCount++;
    if ({outValid32, outImm32, outTag32, outErr32} !== 66'h0)
      $display("[TB] FAIL reset32: got v %b imm %h tag %h err %b, required all 0",
               outValid32, outImm32, outTag32, outErr32);
    else passCount++;
    checkCount++;
    if ({outValid64, outImm64, outTag64, outErr64} !== 98'h0)
      $display("[TB] FAIL reset64: got v %b imm %h tag %h err %b, required all 0",
               outValid64, outImm64, outTag64, outErr64);
    else passCount++;
    @(posedge clk); #3; rst = 1'b0;
    @(posedge clk); #1;
    checkCount++;
    if (inReady32 !== 1'b1 || inReady64 !== 1'b1)
      $display("[TB] FAIL reset_in_ready: got %b/%b, required 1/1", inReady32, inReady64);
    else passCount++;
  endtask

  task automatic test_itype();
    outReady = 1'b1;
    sendEntry({12'h800, 13'h0}, ITYPE, 32'd100);
    checkCount++;
    if (outValid32 !== 1'b1 || outImm32 !== 32'hFFFF_F800 || outErr32 !== 1'b0 || outTag32 !== 32'd100)
      $display("[TB] FAIL itype32: got v %b imm %h err %b tag %0d, required v 1 imm fffff800 err 0 tag 100",
               outValid32, outImm32, outErr32, outTag32);
    else passCount++;
    checkCount++;
    if (outImm64 !== 64'hFFFF_FFFF_FFFF_F800)
      $display("[TB] FAIL itype64: got %h, required fffffffffffff800", outImm64);
    else passCount++;
    waitDrain("itype");
  endtask

  task automatic test_xlen64();
    outReady = 1'b1;
    sendEntry({20'h80000, 5'd3}, UTYPE, 32'd101);
    checkCount++;
    if (outImm64 !== 64'hFFFF_FFFF_8000_0000 || outImm32 !== 32'h8000_0000)
      $display("[TB] FAIL utype: got %h / %h, required ffffffff80000000 / 80000000", outImm64, outImm32);
    else passCount++;
    sendEntry({20'hFFDFF, 5'd0}, JTYPE, 32'd102);
    checkCount++;
    if (outImm64 !== 64'hFFFF_FFFF_FFFF_FFFC || outImm32 !== 32'hFFFF_FFFC)
      $display("[TB] FAIL jal_m4: got %h / %h, required fffffffffffffffc / fffffffc", outImm64, outImm32);
    else passCount++;
    waitDrain("xlen64");
  endtask

  task automatic test_shamt_zimm();
    logic [31:0] instr;
    instr = (32'h3F << 20) | (32'h15 << 15) | (32'h7 << 7);
    outReady = 1'b1;
    sendEntry(instr[31:7], SHTYPE, 32'd103);
    checkCount++;
    if (outImm32 !== 32'h1F || outImm64 !== 64'h3F)
      $display("[TB] FAIL shamt: got %h / %h, required 1f / 3f", outImm32, outImm64);
    else passCount++;
    sendEntry(instr[31:7], ZTYPE, 32'd104);
    checkCount++;
    if (outImm32 !== 32'h15 || outImm64 !== 64'h15)
      $display("[TB] FAIL zimm: got %h / %h, required 15 / 15", outImm32, outImm64);
    else passCount++;
    waitDrain("shamt");
  endtask

  task automatic test_illegal();
    logic [2:0] tys [2];
    tys[0] = RTYPE;
    tys[1] = 3'b111;
    outReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sendEntry(25'h1FF_FFFF, tys[k], 32'd105 + 32'(k));
      checkCount++;
      if (outImm32 !== 32'h0 || outErr32 !== 1'b1 || outImm64 !== 64'h0 || outErr64 !== 1'b1)
        $display("[TB] FAIL illegal_%0d: got imm %h/%h err %b/%b, required 0/0 err 1/1",
                 k, outImm32, outImm64, outErr32, outErr64);
      else passCount++;
    end
    waitDrain("illegal");
  endtask

  task automatic test_stall();
    logic [64:0] exp1;
    exp1 = modelImm(25'h0ABCDEF, BTYPE, 1'b0);
    outReady = 1'b0;
    sendEntry(25'h0ABCDEF, BTYPE, 32'd1);
    sendEntry(25'h1234567, STYPE, 32'd2);
    checkCount++;
    if (inReady32 !== 1'b0)
      $display("[TB] FAIL stall_in_ready: got %b after 2 accepts, required 0", inReady32);
    else passCount++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkCount++;
      if (outValid32 !== 1'b1 || outTag32 !== 32'd1 || outImm32 !== exp1[31:0] || inReady32 !== 1'b0)
        $display("[TB] FAIL stall_hold_%0d: got v %b tag %0d imm %h rdy %b, required v 1 tag 1 imm %h rdy 0",
                 c, outValid32, outTag32, outImm32, inReady32, exp1[31:0]);
      else passCount++;
    end
    @(posedge clk); #1;
    outReady = 1'b1;
    sendEntry(25'h0000123, ITYPE, 32'd3);
    sendEntry(25'h1FEDCBA, JTYPE, 32'd4);
    sendEntry(25'h0F0F0F0, UTYPE, 32'd5);
    sendEntry(25'h1555555, BTYPE, 32'd6);
    waitDrain("stall");
  endtask

  task automatic test_flush();
    outReady = 1'b0;
    sendEntry(25'h0111111, ITYPE, 32'd20);
    sendEntry(25'h0222222, ITYPE, 32'd21);
    flush = 1'b1; inValid = 1'b1; inInst = 25'h0333333; inType = ITYPE; inTag = 32'd99;
    @(posedge clk); #1;
    flush = 1'b0; inValid = 1'b0;
    checkCount++;
    if (outValid32 !== 1'b0 || outValid64 !== 1'b0 || inReady32 !== 1'b1)
      $display("[TB] FAIL flush_state: got v %b/%b rdy %b, required v 0/0 rdy 1",
               outValid32, outValid64, inReady32);
    else passCount++;
    outReady = 1'b1;
    sendEntry(25'h0444444, STYPE, 32'd22);
    checkCount++;
    if (outTag32 !== 32'd22)
      $display("[TB] FAIL flush_next: got tag %0d, required 22", outTag32);
    else passCount++;
    waitDrain("flush");
  endtask

  task automatic test_reset_mid();
    outReady = 1'b0;
    sendEntry(25'h1ABCDEF, ITYPE, 32'd30);
    sendEntry(25'h0ABCDEF, UTYPE, 32'd31);
    @(posedge clk); #3;
    rst = 1'b1;
    sbQueue.delete();
    #1;
    checkCount++;
    if ({outValid32, outImm32, outTag32, outErr32} !== 66'h0 || outImm64 !== 64'h0 || outValid64 !== 1'b0)
      $display("[TB] FAIL reset_async: got v %b imm %h tag %h err %b imm64 %h, required all 0",
               outValid32, outImm32, outTag32, outErr32, outImm64);
    else passCount++;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    checkCount++;
    if (inReady32 !== 1'b1)
      $display("[TB] FAIL reset_mid_ready: got %b, required 1", inReady32);
    else passCount++;
    outReady = 1'b1;
    sendEntry(25'h0000FFF, ZTYPE, 32'd32);
    checkCount++;
    if (outValid32 !== 1'b1 || outTag32 !== 32'd32)
      $display("[TB] FAIL reset_mid_latency: got v %b tag %0d, required v 1 tag 32", outValid32, outTag32);
    else passCount++;
    waitDrain("reset_mid");
  endtask

  task automatic test_back_to_back();
    bit senderDone = 1'b0;
    fork
      begin
        for (int n = 0; n < 24; n++)
          sendEntry(25'($urandom), 3'($urandom_range(0, 7)), 32'd200 + 32'(n));
        senderDone = 1'b1;
      end
      begin
        while (!senderDone) begin
          @(posedge clk); #1;
          outReady = 1'($urandom_range(0, 1));
        end
      end
    join
    outReady = 1'b1;
    waitDrain("back_to_back");
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_itype();
    test_xlen64();
    test_shamt_zimm();
    test_illegal();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
